control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter RESET_PC, default 12'h000, SHALL set the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-004 mem_addr  output  16  SHALL be the main-memory address, a 12-bit source zero-extended.
REQ-005 mem_wdata  output  16  SHALL be the memory write data, always equal to acc.
REQ-006 mem_we  output  1  SHALL be the memory write enable.
REQ-007 mem_rdata  input  16  SHALL be the registered memory read data, valid the cycle after mem_addr is presented with mem_we=0.
REQ-008 alu_op  output  4  SHALL be the ALU operation code.
REQ-009 alu_a / alu_b  output  16 each  SHALL be ALU operands: alu_a=acc, alu_b=mem_rdata.
REQ-010 alu_result  input  16  SHALL be the combinational ALU result.
REQ-011 pc  output  12, acc  output  16, ir  output  16, halted  output  1  SHALL expose architectural state.

Function
REQ-012 Instruction format SHALL be ir[15:12]=opcode, ir[11:0]=operand address.
REQ-013 Opcodes SHALL be: 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 JUMP, 8 JZ, 9 SHL, A SHR, F HALT; B-E SHALL be NOP.
REQ-014 FSM states SHALL be FETCH, LOAD_IR, EXEC, WRITEBACK, HALTED.
REQ-015 FETCH: mem_addr=pc, mem_we=0; next LOAD_IR.
REQ-016 LOAD_IR: ir<=mem_rdata, pc<=pc+1 (12-bit wrap, 0xFFF->0x000); next EXEC.
REQ-017 EXEC, LOAD/ADD/SUB/AND/OR/XOR: mem_addr=ir[11:0], mem_we=0; next WRITEBACK.
REQ-018 WRITEBACK: LOAD acc<=mem_rdata; others acc<=alu_result; next FETCH.
REQ-019 alu_op mapping SHALL be ADD 0000, SUB 0001, SHL 0100, SHR 0101, AND 1000, OR 1001, XOR 1010; otherwise 0000.
REQ-020 EXEC STORE: mem_addr=ir[11:0], mem_we=1 for exactly this one cycle; next FETCH.
REQ-021 EXEC JUMP: pc<=ir[11:0]; next FETCH.
REQ-022 EXEC SHL/SHR: acc<=alu_result; no memory access; next FETCH.
REQ-023 EXEC NOP: no state change; next FETCH.
REQ-024 EXEC HALT: next HALTED; HALTED SHALL persist until reset, mem_we=0, pc/acc/ir frozen.
REQ-025 halted SHALL be 1 exactly when state is HALTED.
REQ-026 Latency SHALL be 4 cycles for memory-operand ops, 3 cycles for all others.
REQ-027 Arithmetic SHALL be 16-bit modulo; no flags beyond the acc==0 test.
REQ-028 mem_we SHALL be 0 in every state other than EXEC with STORE.

Reset
REQ-029 With reset=0 at a rising edge: pc<=RESET_PC, acc<=0, ir<=0, state<=FETCH.
REQ-030 While reset=0, mem_we SHALL be forced 0 combinationally, including reset asserted mid-instruction; the aborted instruction SHALL have no architectural effect.

Configuration
REQ-031 CTRL_JZ_EN defined: opcode 8 JZ SHALL set pc<=ir[11:0] in EXEC if acc==16'h0000, else no effect.
REQ-032 CTRL_JZ_EN undefined: opcode 8 SHALL execute as NOP, 3 cycles.

Verification
REQ-033 mem: 0:LOAD 0x100, 1:ADD 0x101, 2:STORE 0x102, 3:HALT, [0x100]=5, [0x101]=7 -> mem[0x102]=12, halted=1 after 14th edge.
REQ-034 LOAD 0x100 (=3), SUB 0x101 (=5) -> acc=16'hFFFE, alu_op=0001 during WRITEBACK.
REQ-035 pc=0xFFF holding NOP -> pc=0x000 after LOAD_IR; 0:JUMP 0x010 -> next fetch address 0x010.
REQ-036 acc=0, JZ 0x020 -> pc=0x020 with CTRL_JZ_EN; pc=next sequential without it; acc=1 -> no jump either build.
REQ-037 reset=0 during STORE EXEC -> mem_we=0 that cycle, memory unchanged; after release pc=RESET_PC, mem_addr=0, acc=0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle accumulator CPU controller (FETCH / LOAD_IR / EXEC / WRITEBACK / HALTED).
// Build option: define CTRL_JZ_EN to make opcode 8 jump when acc is zero; undefined, opcode 8 is a NOP.
module control_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic [11:0] pc,
  output logic [15:0] acc,
  output logic [15:0] ir,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_LOAD_IR,
    S_EXEC,
    S_WRITEBACK,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t      r_state;
  state_t      w_next_state;
  logic [11:0] r_pc;
  logic [15:0] r_acc;
  logic [15:0] r_ir;
  logic [3:0]  w_opcode;
  logic        w_mem_op;
  logic        w_shift_op;
  logic        w_jz_take;

  assign w_opcode   = r_ir[15:12];
  assign w_mem_op   = (w_opcode == OP_LOAD) || (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                      (w_opcode == OP_AND)  || (w_opcode == OP_OR)  || (w_opcode == OP_XOR);
  assign w_shift_op = (w_opcode == OP_SHL) || (w_opcode == OP_SHR);

`ifdef CTRL_JZ_EN
  localparam logic [3:0] OP_JZ = 4'h8;
  assign w_jz_take = (w_opcode == OP_JZ) && (r_acc == 16'h0000);
`else
  assign w_jz_take = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:     w_next_state = S_LOAD_IR;
      S_LOAD_IR:   w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_opcode == OP_HALT) w_next_state = S_HALTED;
        else if (w_mem_op)       w_next_state = S_WRITEBACK;
        else                     w_next_state = S_FETCH;
      end
      S_WRITEBACK: w_next_state = S_FETCH;
      S_HALTED:    w_next_state = S_HALTED;
      default:     w_next_state = S_FETCH;
    endcase
  end

  // Architectural registers; an instruction aborted by reset never commits anything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc  <= RESET_PC;
      r_acc <= 16'h0000;
      r_ir  <= 16'h0000;
    end else begin
      case (r_state)
        S_LOAD_IR: begin
          r_ir <= mem_rdata;
          r_pc <= r_pc + 12'd1;
        end
        S_EXEC: begin
          if ((w_opcode == OP_JUMP) || w_jz_take) r_pc <= r_ir[11:0];
          if (w_shift_op)                         r_acc <= alu_result;
        end
        S_WRITEBACK: r_acc <= (w_opcode == OP_LOAD) ? mem_rdata : alu_result;
        default: ;
      endcase
    end
  end

  // Memory port: the write strobe is gated by reset so a store cut short by reset never lands.
  always_comb begin
    mem_addr = {4'h0, r_pc};
    mem_we   = 1'b0;
    if ((r_state == S_EXEC) && (w_mem_op || (w_opcode == OP_STORE)))
      mem_addr = {4'h0, r_ir[11:0]};
    if ((r_state == S_EXEC) && (w_opcode == OP_STORE) && reset)
      mem_we = 1'b1;
  end

  always_comb begin
    alu_op = 4'b0000;
    case (w_opcode)
      OP_ADD: alu_op = 4'b0000;
      OP_SUB: alu_op = 4'b0001;
      OP_SHL: alu_op = 4'b0100;
      OP_SHR: alu_op = 4'b0101;
      OP_AND: alu_op = 4'b1000;
      OP_OR:  alu_op = 4'b1001;
      OP_XOR: alu_op = 4'b1010;
      default: alu_op = 4'b0000;
    endcase
  end

  assign mem_wdata = r_acc;
  assign alu_a     = r_acc;
  assign alu_b     = mem_rdata;
  assign pc        = r_pc;
  assign acc       = r_acc;
  assign ir        = r_ir;
  assign halted    = (r_state == S_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: registered-read memory and reference ALU model around the DUT.
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic [11:0] pc;
  logic [15:0] acc;
  logic [15:0] ir;
  logic        halted;

  logic [15:0] mem [0:4095];
  logic        p_en;
  logic [11:0] p_addr;
  logic [15:0] p_data;
  logic [11:0] jz_exp;

  int n_cmp  = 0;
  int n_fail = 0;

  control_sequencer #(.RESET_PC(12'h000)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .pc         (pc),
    .acc        (acc),
    .ir         (ir),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data is registered; bench pokes share the same write port.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[11:0]];
    if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    if (p_en)   mem[p_addr] <= p_data;
  end

  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0100: alu_result = alu_a << 1;
      4'b0101: alu_result = alu_a >> 1;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] addr, input logic [15:0] data);
    p_en   = 1'b1;
    p_addr = addr;
    p_data = data;
    tick(1);
    p_en   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b0;
    p_en   = 1'b0;
    p_addr = 12'h000;
    p_data = 16'h0000;
    tick(2);

    // LOAD / ADD / STORE / HALT program; halts after the 14th edge.
    poke(12'h000, 16'h0100);
    poke(12'h001, 16'h2101);
    poke(12'h002, 16'h1102);
    poke(12'h003, 16'hF000);
    poke(12'h100, 16'h0005);
    poke(12'h101, 16'h0007);
    poke(12'h102, 16'h0000);
    check("rst_pc",       {4'h0, pc}, 16'h0000);
    check("rst_acc",      acc, 16'h0000);
    check("rst_ir",       ir, 16'h0000);
    check("rst_halted",   {15'h0, halted}, 16'h0000);
    check("rst_mem_we",   {15'h0, mem_we}, 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);
    reset = 1'b1;
    tick(4);
    check("p1_load_acc", acc, 16'h0005);
    check("p1_load_pc",  {4'h0, pc}, 16'h0001);
    tick(6);
    check("p1_store_we",    {15'h0, mem_we}, 16'h0001);
    check("p1_store_addr",  mem_addr, 16'h0102);
    check("p1_store_wdata", mem_wdata, 16'h000C);
    tick(3);
    check("p1_halted_e13", {15'h0, halted}, 16'h0000);
    tick(1);
    check("p1_halted_e14", {15'h0, halted}, 16'h0001);
    check("p1_mem102",     mem[12'h102], 16'h000C);
    check("p1_pc_halt",    {4'h0, pc}, 16'h0004);
    check("p1_ir_halt",    ir, 16'hF000);
    tick(3);
    check("p1_halt_hold",  {15'h0, halted}, 16'h0001);
    check("p1_pc_frozen",  {4'h0, pc}, 16'h0004);
    check("p1_acc_frozen", acc, 16'h000C);
    check("p1_we_halted",  {15'h0, mem_we}, 16'h0000);

    // SUB wraps below zero; alu_op visible during WRITEBACK.
    reset = 1'b0;
    poke(12'h000, 16'h0100);
    poke(12'h001, 16'h3101);
    poke(12'h002, 16'hF000);
    poke(12'h100, 16'h0003);
    poke(12'h101, 16'h0005);
    reset = 1'b1;
    tick(7);
    check("sub_alu_op", {12'h0, alu_op}, 16'h0001);
    check("sub_alu_a",  alu_a, 16'h0003);
    check("sub_alu_b",  alu_b, 16'h0005);
    tick(1);
    check("sub_acc", acc, 16'hFFFE);

    // Logic ops and shifts.
    reset = 1'b0;
    poke(12'h000, 16'h0100);
    poke(12'h001, 16'h4101);
    poke(12'h002, 16'h5102);
    poke(12'h003, 16'h6103);
    poke(12'h004, 16'h9000);
    poke(12'h005, 16'hA000);
    poke(12'h006, 16'hF000);
    poke(12'h100, 16'h00F0);
    poke(12'h101, 16'h0F3C);
    poke(12'h102, 16'h8001);
    poke(12'h103, 16'h00FF);
    reset = 1'b1;
    tick(4);
    check("lg_load_acc", acc, 16'h00F0);
    tick(3);
    check("lg_and_op", {12'h0, alu_op}, 16'h0008);
    tick(1);
    check("lg_and_acc", acc, 16'h0030);
    tick(3);
    check("lg_or_op", {12'h0, alu_op}, 16'h0009);
    tick(1);
    check("lg_or_acc", acc, 16'h8031);
    tick(3);
    check("lg_xor_op", {12'h0, alu_op}, 16'h000A);
    tick(1);
    check("lg_xor_acc", acc, 16'h80CE);
    tick(2);
    check("lg_shl_op", {12'h0, alu_op}, 16'h0004);
    check("lg_shl_we", {15'h0, mem_we}, 16'h0000);
    tick(1);
    check("lg_shl_acc", acc, 16'h019C);
    tick(2);
    check("lg_shr_op", {12'h0, alu_op}, 16'h0005);
    tick(1);
    check("lg_shr_acc", acc, 16'h00CE);
    tick(3);
    check("lg_halted", {15'h0, halted}, 16'h0001);

    // JUMP target fetch and PC wrap through a NOP at 0xFFF.
    reset = 1'b0;
    poke(12'h000, 16'h7010);
    poke(12'h010, 16'h7FFF);
    poke(12'hFFF, 16'hB000);
    reset = 1'b1;
    check("jmp_fetch0", mem_addr, 16'h0000);
    tick(3);
    check("jmp_fetch_010", mem_addr, 16'h0010);
    check("jmp_pc_010",    {4'h0, pc}, 16'h0010);
    tick(3);
    check("jmp_fetch_fff", mem_addr, 16'h0FFF);
    tick(2);
    check("wrap_pc",  {4'h0, pc}, 16'h0000);
    check("wrap_ir",  ir, 16'hB000);
    tick(1);
    check("wrap_fetch", mem_addr, 16'h0000);
    check("nop_acc",    acc, 16'h0000);

    // JZ with acc == 0, then with acc == 1.
`ifdef CTRL_JZ_EN
    jz_exp = 12'h020;
`else
    jz_exp = 12'h001;
`endif
    reset = 1'b0;
    poke(12'h000, 16'h8020);
    poke(12'h001, 16'hF000);
    poke(12'h020, 16'hF000);
    reset = 1'b1;
    tick(3);
    check("jz_zero_pc", {4'h0, pc}, {4'h0, jz_exp});
    reset = 1'b0;
    poke(12'h000, 16'h0100);
    poke(12'h001, 16'h8020);
    poke(12'h002, 16'hF000);
    poke(12'h100, 16'h0001);
    reset = 1'b1;
    tick(7);
    check("jz_nz_pc",  {4'h0, pc}, 16'h0002);
    check("jz_nz_acc", acc, 16'h0001);

    // Reset asserted during STORE EXEC.
    reset = 1'b0;
    poke(12'h000, 16'h0100);
    poke(12'h001, 16'h1102);
    poke(12'h002, 16'hF000);
    poke(12'h100, 16'h1234);
    poke(12'h102, 16'hAAAA);
    reset = 1'b1;
    tick(4);
    check("rs_load_acc", acc, 16'h1234);
    tick(2);
    check("rs_we_before", {15'h0, mem_we}, 16'h0001);
    reset = 1'b0;
    #1;
    check("rs_we_forced", {15'h0, mem_we}, 16'h0000);
    tick(1);
    check("rs_mem_kept", mem[12'h102], 16'hAAAA);
    check("rs_pc",       {4'h0, pc}, 16'h0000);
    check("rs_acc",      acc, 16'h0000);
    check("rs_ir",       ir, 16'h0000);
    reset = 1'b1;
    #1;
    check("rs_rel_addr", mem_addr, 16'h0000);
    check("rs_rel_pc",   {4'h0, pc}, 16'h0000);
    check("rs_rel_acc",  acc, 16'h0000);
    check("rs_rel_halt", {15'h0, halted}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
